// File: rtl/burst_pipeline_pkg.sv
// burst_pipeline_pkg: shared types and constants for the burst read/write pipelines
package burst_pipeline_pkg;
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  typedef logic [7:0] len_t;
  localparam len_t LEN_IDLE = 8'hFF;
endpackage

// File: rtl/burst_write_pipeline_if.sv
// burst_write_pipeline_if: command, beat, memory-write and response signals of the write pipeline
interface burst_write_pipeline_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  import burst_pipeline_pkg::*;
  logic [ADDR_WIDTH-1:0] u_addr;
  len_t                  u_length;
  logic                  u_valid;
  logic                  u_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_last;
  logic                  w_valid;
  logic                  w_ready;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_we;
  logic                  b_valid;
  logic                  b_error;
  logic                  b_ready;
  modport master (
    output u_addr, u_length, u_valid, w_data, w_last, w_valid, b_ready,
    input  u_ready, w_ready, m_addr, m_data, m_we, b_valid, b_error
  );
  modport slave (
    input  u_addr, u_length, u_valid, w_data, w_last, w_valid, b_ready,
    output u_ready, w_ready, m_addr, m_data, m_we, b_valid, b_error
  );
endinterface

// File: rtl/burst_beat_counter.sv
// burst_beat_counter: per-burst word address and remaining-beat counter
module burst_beat_counter
  import burst_pipeline_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  len_t                  i_length,
  input  logic                  i_step,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output len_t                  o_count,
  output logic                  o_is_last
);
  logic [ADDR_WIDTH-1:0] r_addr;
  len_t                  r_count;

  // load the burst on a command, advance address and count on every beat; the
  // count falls back to LEN_IDLE after the final beat so is_last stays low when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_count <= LEN_IDLE;
    end else if (i_load) begin
      r_addr  <= i_addr;
      r_count <= i_length;
    end else if (i_step) begin
      r_addr  <= r_addr + 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

  assign o_addr    = r_addr;
  assign o_count   = r_count;
  assign o_is_last = r_count == 8'h00;
endmodule

// File: rtl/burst_write_pipeline.sv
// burst_write_pipeline: turns a burst command plus data beats into one registered memory write per beat
module burst_write_pipeline
  import burst_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int MAX_BURST_LENGTH = 4
) (
  input logic clk,
  input logic rst_n,
  burst_write_pipeline_if.slave bus
);
  localparam len_t MAX_LEN = len_t'(MAX_BURST_LENGTH - 1);

  state_t                r_state;
  state_t                w_next;
  logic                  r_live;
  logic                  r_len_err;
  logic                  r_last_err;
  logic                  r_m_we;
  logic [ADDR_WIDTH-1:0] r_m_addr;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  w_cmd;
  logic                  w_beat;
  logic [ADDR_WIDTH-1:0] w_addr;
  len_t                  w_count;
  logic                  w_is_last;

  assign w_cmd  = (r_state == IDLE) && r_live && bus.u_valid;
  assign w_beat = (r_state == DATA) && bus.w_valid;

  burst_beat_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_cmd),
    .i_addr   (bus.u_addr),
    .i_length (bus.u_length),
    .i_step   (w_beat),
    .o_addr   (w_addr),
    .o_count  (w_count),
    .o_is_last(w_is_last)
  );

  // state register; r_live keeps u_ready low until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end

  // next state: the counter alone ends a burst, w_last only feeds the error flag
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_cmd ? DATA : IDLE;
      DATA:    w_next = (w_beat && w_is_last) ? RESP : DATA;
      RESP:    w_next = bus.b_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end

  // error flags: length checked at command time, w_last checked on every beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_err  <= 1'b0;
      r_last_err <= 1'b0;
    end else if (w_cmd) begin
      r_len_err  <= bus.u_length > MAX_LEN;
      r_last_err <= 1'b0;
    end else if (w_beat && (bus.w_last != w_is_last)) begin
      r_last_err <= 1'b1;
    end
  end

  // registered memory write; oversize bursts are drained without writing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_we   <= 1'b0;
      r_m_addr <= '0;
      r_m_data <= '0;
    end else begin
      r_m_we   <= w_beat && !r_len_err;
      r_m_addr <= w_beat ? w_addr : r_m_addr;
      r_m_data <= w_beat ? bus.w_data : r_m_data;
    end
  end

  assign bus.u_ready = (r_state == IDLE) && r_live;
  assign bus.w_ready = r_state == DATA;
  assign bus.b_valid = r_state == RESP;
  assign bus.b_error = (r_state == RESP) && (r_len_err || r_last_err);
  assign bus.m_we    = r_m_we;
  assign bus.m_addr  = r_m_addr;
  assign bus.m_data  = r_m_data;
endmodule

// File: tb/tb_burst_write_pipeline.sv
// tb_burst_write_pipeline: directed checks of the burst write pipeline
module tb_burst_write_pipeline;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  int we_base;
  logic [7:0] wrap_exp [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  burst_write_pipeline_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ua ();
  burst_write_pipeline_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8))  ub ();

  burst_write_pipeline #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST_LENGTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ua.slave));
  burst_write_pipeline #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MAX_BURST_LENGTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ub.slave));

  always #5 clk = ~clk;

  always @(negedge clk) if (ua.m_we === 1'b1) we_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [31:0] addr, input logic [7:0] len);
    chk("cmd_u_ready", ua.u_ready, 1'b1);
    ua.u_addr = addr;
    ua.u_length = len;
    ua.u_valid = 1'b1;
    tick();
    ua.u_valid = 1'b0;
    chk("cmd_w_ready", ua.w_ready, 1'b1);
    chk("cmd_u_ready_low", ua.u_ready, 1'b0);
  endtask

  task automatic beat(input logic [31:0] data, input logic last);
    ua.w_data = data;
    ua.w_last = last;
    ua.w_valid = 1'b1;
    tick();
    ua.w_valid = 1'b0;
  endtask

  task automatic resp(input logic err);
    chk("resp_b_valid", ua.b_valid, 1'b1);
    chk("resp_b_error", ua.b_error, err);
    ua.b_ready = 1'b1;
    tick();
    ua.b_ready = 1'b0;
    chk("resp_u_ready", ua.u_ready, 1'b1);
    chk("resp_b_valid_low", ua.b_valid, 1'b0);
  endtask

  initial begin
    {ua.u_valid, ua.w_valid, ua.w_last, ua.b_ready} = '0;
    {ub.u_valid, ub.w_valid, ub.w_last, ub.b_ready} = '0;
    ua.u_addr = '0; ua.u_length = '0; ua.w_data = '0;
    ub.u_addr = '0; ub.u_length = '0; ub.w_data = '0;
    tick();
    tick();
    chk("rst_u_ready", ua.u_ready, 1'b0);
    chk("rst_w_ready", ua.w_ready, 1'b0);
    chk("rst_m_we", ua.m_we, 1'b0);
    chk("rst_m_addr", ua.m_addr, 32'h0);
    chk("rst_m_data", ua.m_data, 32'h0);
    chk("rst_b_valid", ua.b_valid, 1'b0);
    chk("rst_b_error", ua.b_error, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_u_ready", ua.u_ready, 1'b1);
    chk("idle_w_ready", ua.w_ready, 1'b0);

    // nominal burst, back-to-back beats
    cmd(32'h100, 8'd3);
    we_base = we_cnt;
    for (int i = 0; i < 4; i++) begin
      beat(32'hA0 + i, i == 3);
      chk("nom_m_we", ua.m_we, 1'b1);
      chk("nom_m_addr", ua.m_addr, 32'h100 + i);
      chk("nom_m_data", ua.m_data, 32'hA0 + i);
      chk("nom_b_valid", ua.b_valid, i == 3);
    end
    resp(1'b0);
    chk("nom_m_we_off", ua.m_we, 1'b0);
    chk("nom_we_count", we_cnt - we_base, 4);

    // backpressure gaps and delayed b_ready
    cmd(32'h200, 8'd2);
    we_base = we_cnt;
    for (int i = 0; i < 3; i++) begin
      beat(32'hB0 + i, i == 2);
      chk("bp_m_addr", ua.m_addr, 32'h200 + i);
      chk("bp_m_data", ua.m_data, 32'hB0 + i);
      if (i < 2) begin
        tick();
        chk("bp_gap_m_we", ua.m_we, 1'b0);
        chk("bp_gap_b_valid", ua.b_valid, 1'b0);
        tick();
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_b_valid", ua.b_valid, 1'b1);
      chk("bp_hold_b_error", ua.b_error, 1'b0);
      tick();
    end
    resp(1'b0);
    chk("bp_we_count", we_cnt - we_base, 3);

    // oversize burst is drained without any write
    cmd(32'h300, 8'd5);
    we_base = we_cnt;
    for (int i = 0; i < 6; i++) begin
      chk("len_w_ready", ua.w_ready, 1'b1);
      beat(32'hC0 + i, i == 5);
      chk("len_m_we", ua.m_we, 1'b0);
    end
    resp(1'b1);
    chk("len_we_count", we_cnt - we_base, 0);

    // w_last early: still four writes, error reported
    cmd(32'h340, 8'd3);
    we_base = we_cnt;
    for (int i = 0; i < 4; i++) begin
      beat(32'hD0 + i, i == 1);
      chk("last_m_we", ua.m_we, 1'b1);
      chk("last_b_valid", ua.b_valid, i == 3);
    end
    resp(1'b1);
    chk("last_we_count", we_cnt - we_base, 4);

    // single-beat burst with w_last missing
    cmd(32'h380, 8'd0);
    we_base = we_cnt;
    beat(32'hE0, 1'b0);
    chk("one_m_addr", ua.m_addr, 32'h380);
    chk("one_m_data", ua.m_data, 32'hE0);
    resp(1'b1);
    chk("one_we_count", we_cnt - we_base, 1);

    // address wrap on the 8-bit instance
    chk("wrap_u_ready", ub.u_ready, 1'b1);
    ub.u_addr = 8'hFE;
    ub.u_length = 8'd3;
    ub.u_valid = 1'b1;
    tick();
    ub.u_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ub.w_data = 32'hF0 + i;
      ub.w_last = i == 3;
      ub.w_valid = 1'b1;
      tick();
      ub.w_valid = 1'b0;
      chk("wrap_m_we", ub.m_we, 1'b1);
      chk("wrap_m_addr", ub.m_addr, wrap_exp[i]);
    end
    chk("wrap_b_valid", ub.b_valid, 1'b1);
    chk("wrap_b_error", ub.b_error, 1'b0);
    ub.b_ready = 1'b1;
    tick();
    ub.b_ready = 1'b0;
    chk("wrap_u_ready_after", ub.u_ready, 1'b1);

    // reset in the middle of a burst
    cmd(32'h400, 8'd3);
    beat(32'h40, 1'b0);
    beat(32'h41, 1'b0);
    chk("mid_m_we", ua.m_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_u_ready", ua.u_ready, 1'b0);
    chk("mid_rst_w_ready", ua.w_ready, 1'b0);
    chk("mid_rst_m_we", ua.m_we, 1'b0);
    chk("mid_rst_m_addr", ua.m_addr, 32'h0);
    chk("mid_rst_m_data", ua.m_data, 32'h0);
    chk("mid_rst_b_valid", ua.b_valid, 1'b0);
    we_base = we_cnt;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_post_b_valid", ua.b_valid, 1'b0);
    end
    chk("mid_post_we", we_cnt - we_base, 0);
    cmd(32'h500, 8'd0);
    beat(32'h55, 1'b1);
    chk("mid_new_m_we", ua.m_we, 1'b1);
    chk("mid_new_m_addr", ua.m_addr, 32'h500);
    chk("mid_new_m_data", ua.m_data, 32'h55);
    resp(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/burst_write_pipeline.md
# burst_write_pipeline

Write-direction counterpart of the burst read pipeline: accepts a burst command (start address, length−1), then the burst's data beats, and issues one registered memory write per beat at consecutive word addresses. It sits between a burst master and a single-port memory write interface. When the burst completes, it returns a single response carrying an error flag.

## Interface
- DATA_WIDTH, 32, data and memory word width in bits
- ADDR_WIDTH, 32, word address width in bits
- MAX_BURST_LENGTH, 4, largest legal burst in beats; longer commands are flagged as errors
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- u_addr  in  ADDR_WIDTH  burst start address
- u_length  in  8  burst length − 1
- u_valid  in  1  command valid
- u_ready  out  1  command ready
- w_data  in  DATA_WIDTH  write beat data
- w_last  in  1  master's last-beat marker
- w_valid  in  1  beat valid
- w_ready  out  1  beat ready
- m_addr  out  ADDR_WIDTH  memory write address (registered)
- m_data  out  DATA_WIDTH  memory write data (registered)
- m_we  out  1  memory write enable, one-cycle pulse per write
- b_valid  out  1  burst response valid
- b_error  out  1  response error flag, valid with b_valid
- b_ready  in  1  response ready

## Operation
- The FSM has three states: IDLE, DATA, RESP. Reset state is IDLE.
- IDLE:
  - u_ready=1; w_ready=0.
  - On u_valid: latch addr=u_addr and count=u_length.
  - Set len_err = (u_length > MAX_BURST_LENGTH−1). Clear last_err. Go to DATA.
- DATA:
  - u_ready=0; w_ready=1.
  - Each w_valid&&w_ready beat writes to the memory port unless len_err. The write is registered: m_addr=addr, m_data=w_data, m_we=!len_err.
  - After each beat: addr+1, count−1.
  - The beat taken with count==0 is the final beat and moves the FSM to RESP.
  - The burst end is decided by the counter only; w_last never terminates a burst early.
  - A beat where w_last != (count==0) sets last_err. That beat is still written.
  - With len_err set, all length+1 beats are still consumed (drained) but never written.
- RESP:
  - b_valid=1 and b_error=len_err||last_err, both held stable until b_ready.
  - On b_ready, go to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH; 0xFF..F + 1 wraps to 0 within a burst.
- u_length=0 is a legal single-beat burst. u_length=0xFF gives 256 beats with len_err.
- Reset values: u_ready=0 during reset and 1 after release; w_ready=0; m_we=0; m_addr=0; m_data=0; b_valid=0; b_error=0.
- Reset asserted mid-burst abandons the burst: no response, no further m_we, FSM to IDLE.

## Timing
- Command handshake in cycle N → w_ready=1 from cycle N+1.
- Beat handshake in cycle K → m_we/m_addr/m_data visible in cycle K+1. m_we deasserts in any cycle following no handshake.
- Throughput is one beat per cycle while w_valid is held.
- Final beat in cycle K → b_valid=1 in cycle K+1. Its m_we pulse occurs in the same cycle K+1.
- b_ready in cycle R → u_ready=1 in cycle R+1.
- The minimum command-to-command interval is length+1 beats plus 2 cycles.
- u_ready, w_ready and b_valid are decoded from the state register only, with no combinational path from inputs.
- w_valid in IDLE or RESP is ignored; it is not a handshake.

## Structure
- Shared package burst_pipeline_pkg holds:
  - the state enum (IDLE, DATA, RESP);
  - the 8-bit length type;
  - the constant LEN_IDLE = 8'hFF, shared with the read pipeline.
- Natural sub-module: burst_beat_counter.
  - Inputs: load, length and step.
  - Outputs: the address and count registers, and an is_last flag.
  - The read pipeline will reuse it.
- Everything else lives in burst_write_pipeline. The target size is about 150–250 lines.

## Test plan
- Nominal burst: cmd addr=0x100, len=3; beats 0xA0..0xA3 back-to-back with w_last on beat 4. Required: m_we on 4 consecutive cycles to 0x100..0x103 with data 0xA0..0xA3; b_valid one cycle after beat 4; b_error=0.
- Backpressure gaps: len=2, w_valid low for 2 cycles between each beat and b_ready held low 3 cycles. Required: exactly 3 m_we pulses; b_valid/b_error stable until b_ready; u_ready=1 the cycle after b_ready.
- Length error: MAX=4, len=5; 6 beats supplied. Required: all 6 beats accepted, m_we never asserted, b_error=1.
- w_last mismatch: len=3 with w_last on beat 2. Required: 4 writes performed, b_error=1. Also len=0 with w_last=0 → 1 write, b_error=1.
- Address wrap: ADDR_WIDTH=8, addr=0xFE, len=3. Required: writes to 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-burst: assert rst_n low after beat 2 of a len=3 burst. Required: all outputs at reset values immediately; no b_valid after release; a new len=0 command completes normally.
